// File: rtl/link_writer.sv
// link_writer: appends pages to the tail of the link-table list in page RAM.
// Optional LINK_TERMINATE_EN also writes a null next-pointer into the new page.
module link_writer #(
    parameter int ADDR_WIDTH        = 16,
    parameter int ADDR_PAGE_NUM_LOG = 12,
    parameter int DATA_WIDTH        = 8,
    parameter int PAGE_SIZE_LOG     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_append_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0] i_append_page,
    output logic                         o_append_ready,
    output logic                         o_append_done,
    input  logic                         i_pop_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0] i_pop_next_page,
    output logic                         o_ram_write_req,
    input  logic                         i_ram_write_ready,
    output logic [ADDR_WIDTH-1:0]        o_ram_write_addr,
    output logic [DATA_WIDTH-1:0]        o_ram_write_data,
    output logic                         o_table_write_req,
    output logic [ADDR_PAGE_NUM_LOG-1:0] o_table_write_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] o_head_page,
    output logic [ADDR_PAGE_NUM_LOG-1:0] o_tail_page,
    output logic [ADDR_PAGE_NUM_LOG:0]   o_page_count,
    output logic                         o_table_empty
);

    localparam int PN = ADDR_PAGE_NUM_LOG;
    localparam int CW = ADDR_PAGE_NUM_LOG + 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] L_FULL = {1'b1, {PN{1'b0}}};
    localparam logic [CW-1:0] L_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_TERM_LO,
        S_TERM_HI,
        S_COMMIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PN-1:0]   r_page;
    logic [PN-1:0]   r_head;
    logic [PN-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_empty;
    logic            r_ready;

    logic            w_accept;
    logic            w_commit;
    logic            w_pop;
    logic            w_list_empty;
    logic            w_wr_req;
    logic [CW-1:0]   w_count_nxt;
    logic [PN-1:0]   w_head_nxt;
    logic [PW-1:0]   w_ptr;
    logic [ADDR_WIDTH-1:0] w_tail_base;

    assign w_list_empty = (r_count == '0);
    assign w_accept     = (r_state == S_IDLE) && i_append_req && r_ready;
    assign w_commit     = (r_state == S_COMMIT);
    assign w_pop        = i_pop_req && !w_list_empty;
    assign w_ptr        = PW'(r_page);
    assign w_tail_base  = ADDR_WIDTH'({r_tail, {PAGE_SIZE_LOG{1'b0}}});

`ifdef LINK_TERMINATE_EN
    logic [ADDR_WIDTH-1:0] w_page_base;
    assign w_page_base = ADDR_WIDTH'({r_page, {PAGE_SIZE_LOG{1'b0}}});
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef LINK_TERMINATE_EN
                    w_state_nxt = w_list_empty ? S_TERM_LO : S_WR_LO;
`else
                    w_state_nxt = w_list_empty ? S_COMMIT : S_WR_LO;
`endif
                end
            end
            S_WR_LO: begin
                if (i_ram_write_ready) w_state_nxt = S_WR_HI;
            end
            S_WR_HI: begin
                if (i_ram_write_ready) begin
`ifdef LINK_TERMINATE_EN
                    w_state_nxt = S_TERM_LO;
`else
                    w_state_nxt = S_COMMIT;
`endif
                end
            end
`ifdef LINK_TERMINATE_EN
            S_TERM_LO: begin
                if (i_ram_write_ready) w_state_nxt = S_TERM_HI;
            end
            S_TERM_HI: begin
                if (i_ram_write_ready) w_state_nxt = S_COMMIT;
            end
`endif
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wr_req           = 1'b0;
        o_ram_write_addr   = '0;
        o_ram_write_data   = '0;
        o_table_write_req  = 1'b0;
        o_table_write_addr = '0;
        o_append_done      = 1'b0;
        unique case (r_state)
            S_WR_LO: begin
                w_wr_req         = 1'b1;
                o_ram_write_addr = w_tail_base;
                o_ram_write_data = w_ptr[DATA_WIDTH-1:0];
            end
            S_WR_HI: begin
                w_wr_req         = 1'b1;
                o_ram_write_addr = w_tail_base + ADDR_WIDTH'(1);
                o_ram_write_data = w_ptr[PW-1:DATA_WIDTH];
            end
`ifdef LINK_TERMINATE_EN
            S_TERM_LO: begin
                w_wr_req         = 1'b1;
                o_ram_write_addr = w_page_base;
                o_ram_write_data = '1;
            end
            S_TERM_HI: begin
                w_wr_req         = 1'b1;
                o_ram_write_addr = w_page_base + ADDR_WIDTH'(1);
                o_ram_write_data = '1;
            end
`endif
            S_COMMIT: begin
                o_table_write_req  = 1'b1;
                o_table_write_addr = r_page;
                o_append_done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset kills the strobe in the same cycle so no partial link write lands.
    assign o_ram_write_req = w_wr_req && !i_rst;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_commit, w_pop})
            2'b10:   w_count_nxt = r_count + L_ONE;
            2'b01:   w_count_nxt = r_count - L_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // A pop that empties the list leaves head stale; a coincident commit
    // replaces the popped page with the appended one.
    always_comb begin
        w_head_nxt = r_head;
        if (w_commit) begin
            if (w_list_empty || (w_pop && r_count == L_ONE)) begin
                w_head_nxt = r_page;
            end else if (w_pop) begin
                w_head_nxt = i_pop_next_page;
            end
        end else if (w_pop && r_count != L_ONE) begin
            w_head_nxt = i_pop_next_page;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_page  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_ready <= 1'b1;
        end else begin
            if (w_accept) r_page <= i_append_page;
            if (w_commit) r_tail <= r_page;
            r_head  <= w_head_nxt;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_ready <= (w_state_nxt == S_IDLE) && (w_count_nxt != L_FULL);
        end
    end

    assign o_append_ready = r_ready;
    assign o_head_page    = r_head;
    assign o_tail_page    = r_tail;
    assign o_page_count   = r_count;
    assign o_table_empty  = r_empty;

endmodule

// File: tb/tb_link_writer.sv
// Randomized scoreboard bench for link_writer against a queue model of the list.
module tb_link_writer;

    localparam int AW = 16;
    localparam int PN = 12;
    localparam int DW = 8;
    localparam int FULLN = 4096;
`ifdef LINK_TERMINATE_EN
    localparam int TERM = 1;
`else
    localparam int TERM = 0;
`endif

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_append_req;
    logic [PN-1:0] i_append_page;
    logic          o_append_ready;
    logic          o_append_done;
    logic          i_pop_req;
    logic [PN-1:0] i_pop_next_page;
    logic          o_ram_write_req;
    logic          i_ram_write_ready;
    logic [AW-1:0] o_ram_write_addr;
    logic [DW-1:0] o_ram_write_data;
    logic          o_table_write_req;
    logic [PN-1:0] o_table_write_addr;
    logic [PN-1:0] o_head_page;
    logic [PN-1:0] o_tail_page;
    logic [PN:0]   o_page_count;
    logic          o_table_empty;

    always #5 clk = ~clk;

    link_writer dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_append_req       (i_append_req),
        .i_append_page      (i_append_page),
        .o_append_ready     (o_append_ready),
        .o_append_done      (o_append_done),
        .i_pop_req          (i_pop_req),
        .i_pop_next_page    (i_pop_next_page),
        .o_ram_write_req    (o_ram_write_req),
        .i_ram_write_ready  (i_ram_write_ready),
        .o_ram_write_addr   (o_ram_write_addr),
        .o_ram_write_data   (o_ram_write_data),
        .o_table_write_req  (o_table_write_req),
        .o_table_write_addr (o_table_write_addr),
        .o_head_page        (o_head_page),
        .o_tail_page        (o_tail_page),
        .o_page_count       (o_page_count),
        .o_table_empty      (o_table_empty)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            n_checks = 0;
    int            n_errs = 0;
    wr_t           exp_wr[$];
    logic [PN-1:0] exp_tbl[$];
    logic [PN-1:0] q[$];
    logic [PN-1:0] m_tail;
    bit            rnd_rdy = 0;

    logic          m_ps = 1'b0;
    logic [AW-1:0] m_pa;
    logic [DW-1:0] m_pd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) i_ram_write_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor: compares every accepted RAM write and table update in order.
    initial begin
        wr_t e;
        logic [PN-1:0] t;
        forever begin
            @(negedge clk);
            if (o_ram_write_req) begin
                if (m_ps) begin
                    chk("hold_addr", 32'(o_ram_write_addr), 32'(m_pa));
                    chk("hold_data", 32'(o_ram_write_data), 32'(m_pd));
                end
                if (i_ram_write_ready) begin
                    n_checks++;
                    if (exp_wr.size() == 0) begin
                        n_errs++;
                        $display("FAIL unexpected_wr: got %0h/%0h expected none",
                                 o_ram_write_addr, o_ram_write_data);
                    end else begin
                        e = exp_wr.pop_front();
                        if (o_ram_write_addr !== e.a || o_ram_write_data !== e.d) begin
                            n_errs++;
                            $display("FAIL ram_wr: got %0h/%0h expected %0h/%0h",
                                     o_ram_write_addr, o_ram_write_data, e.a, e.d);
                        end
                    end
                end
            end
            m_ps = o_ram_write_req && !i_ram_write_ready;
            m_pa = o_ram_write_addr;
            m_pd = o_ram_write_data;
            if (o_table_write_req) begin
                n_checks++;
                if (exp_tbl.size() == 0) begin
                    n_errs++;
                    $display("FAIL unexpected_tbl: got %0h expected none",
                             o_table_write_addr);
                end else begin
                    t = exp_tbl.pop_front();
                    if (o_table_write_addr !== t) begin
                        n_errs++;
                        $display("FAIL tbl_wr: got %0h expected %0h",
                                 o_table_write_addr, t);
                    end
                end
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(o_page_count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(o_table_empty), 32'(q.size() == 0));
        chk({tag, "_ready"}, 32'(o_append_ready), 32'(q.size() != FULLN));
        chk({tag, "_tail"}, 32'(o_tail_page), 32'(m_tail));
        if (q.size() > 0) chk({tag, "_head"}, 32'(o_head_page), 32'(q[0]));
    endtask

    task automatic do_append(input logic [PN-1:0] page, input int stall,
                             input bit pop_c, input bit chk_lat);
        int  n;
        int  w;
        bit  was_empty;
        logic [15:0] ptr;
        logic [AW-1:0] tb;
        w = 0;
        while (!o_append_ready) begin
            tick();
            w++;
            if (w > 20) begin
                chk("ready_timeout", 32'(o_append_ready), 32'(1));
                return;
            end
        end
        was_empty = (q.size() == 0);
        ptr = 16'(page);
        tb = {m_tail, 4'h0};
        if (!was_empty) begin
            exp_wr.push_back('{a: tb, d: ptr[7:0]});
            exp_wr.push_back('{a: tb + 16'd1, d: ptr[15:8]});
        end
        if (TERM != 0) begin
            exp_wr.push_back('{a: {page, 4'h0}, d: 8'hFF});
            exp_wr.push_back('{a: {page, 4'h1}, d: 8'hFF});
        end
        exp_tbl.push_back(page);
        i_append_req = 1'b1;
        i_append_page = page;
        n = 0;
        forever begin
            tick();
            n++;
            i_append_req = 1'b0;
            if (stall > 0) i_ram_write_ready = (n <= stall) ? 1'b0 : 1'b1;
            if (o_append_done) break;
            if (n > 200) begin
                chk("done_timeout", 32'(o_append_done), 32'(1));
                return;
            end
        end
        if (chk_lat)
            chk("latency", 32'(n + 1),
                32'((was_empty ? 2 : 4) + 2 * TERM + stall));
        if (pop_c) begin
            i_pop_req = 1'b1;
            i_pop_next_page = (q.size() > 1) ? q[1] : PN'($urandom);
        end
        tick();
        i_pop_req = 1'b0;
        if (pop_c && q.size() > 0) void'(q.pop_front());
        q.push_back(page);
        m_tail = page;
        check_state("append");
    endtask

    task automatic do_pop();
        i_pop_req = 1'b1;
        i_pop_next_page = (q.size() > 1) ? q[1] : PN'($urandom);
        tick();
        i_pop_req = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_state("pop");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        i_rst = 1'b1;
        i_append_req = 1'b0;
        i_append_page = '0;
        i_pop_req = 1'b0;
        i_pop_next_page = '0;
        i_ram_write_ready = 1'b1;
        m_tail = '0;
        repeat (3) tick();
        i_rst = 1'b0;
        check_state("reset");
        chk("reset_head", 32'(o_head_page), 32'(0));
        chk("reset_done", 32'(o_append_done), 32'(0));
        chk("reset_ramreq", 32'(o_ram_write_req), 32'(0));
        chk("reset_tblreq", 32'(o_table_write_req), 32'(0));

        do_append(12'h010, 0, 0, 1);
        do_append(12'h5A3, 0, 0, 1);
        do_append(12'h123, 3, 0, 1);
        do_append(12'h033, 0, 0, 1);
        while (q.size() > 1) do_pop();
        do_append(12'h022, 0, 1, 1);
        chk("coinc_tail", 32'(o_tail_page), 32'(12'h022));
        chk("coinc_head", 32'(o_head_page), 32'(12'h022));

        rnd_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 6)
                do_append(PN'($urandom), 0, ($urandom_range(0, 4) == 0), 0);
            else
                do_pop();
        end
        rnd_rdy = 0;
        i_ram_write_ready = 1'b1;

        while (q.size() < FULLN) do_append(PN'(q.size() * 7 + 1), 0, 0, 0);
        chk("full_count", 32'(o_page_count), 32'(FULLN));
        chk("full_ready", 32'(o_append_ready), 32'(0));
        seen = 0;
        i_append_req = 1'b1;
        i_append_page = 12'hABC;
        repeat (6) begin
            tick();
            seen |= o_append_done;
        end
        i_append_req = 1'b0;
        chk("full_no_done", 32'(seen), 32'(0));
        chk("full_hold", 32'(o_page_count), 32'(FULLN));
        do_pop();

        i_ram_write_ready = 1'b0;
        i_append_req = 1'b1;
        i_append_page = 12'h3C3;
        tick();
        i_append_req = 1'b0;
        tick();
        chk("midrst_pending", 32'(o_ram_write_req), 32'(1));
        i_rst = 1'b1;
        #1;
        chk("midrst_gate", 32'(o_ram_write_req), 32'(0));
        tick();
        i_rst = 1'b0;
        i_ram_write_ready = 1'b1;
        q.delete();
        m_tail = '0;
        check_state("midrst");
        chk("midrst_head", 32'(o_head_page), 32'(0));

        do_append(12'h7AB, 0, 0, 1);
        do_append(12'h0C4, 0, 0, 1);
        repeat (4) tick();
        chk("wr_left", 32'(exp_wr.size()), 32'(0));
        chk("tbl_left", 32'(exp_tbl.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
